ssd_scan_mux: RTL and testbench

Time-multiplexed scanner for a 4-digit seven-segment display. It takes the 16-bit counter value and emits one nibble at a time to the downstream `ssd_decode_hex` stage, along with one-hot digit enables and a blanking flag.

- Each digit slot opens with a dead-time interval to suppress ghosting.
- The value is captured once per frame, so a display frame never mixes digits from two different counts.

---
 rtl/ssd_scan_mux.sv | 119 +++++++++++
 tb/tb_ssd_scan_mux.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_mux.sv
// Four-digit seven-segment scanner: one nibble per slot, one-hot digit enables, dead-time blanking.
// Optional leading-zero blanking is compiled in when SSD_SCAN_LZB_EN is defined.
module ssd_scan_mux #(
    parameter int CLK_HZ       = 16000000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [15:0] value,
    output logic [3:0]  digit_value,
    output logic [3:0]  digit_sel,
    output logic        digit_blank,
    output logic        frame_done
);

    localparam int DIV = CLK_HZ / DIGIT_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // A zero-length dead time means the slot opens directly in SHOW.
    localparam state_t ST_RESET = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic          r_first;
    state_t        r_state;

    logic          w_wrap;
    logic [PW-1:0] w_presc_nxt;
    logic [1:0]    w_idx_nxt;
    state_t        w_state_nxt;
    logic          w_show;
    logic          w_frame_nxt;

    // Index of the most significant nonzero nibble; 0 when the whole word is zero.
    function automatic logic [1:0] top_digit(input logic [15:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (v[4*i +: 4] != 4'h0) begin
                r = 2'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next-state for the slot counter and digit index, plus the visibility of the current slot.
    always_comb begin
        w_wrap = (r_presc == PRESC_MAX);
        if (w_wrap) begin
            w_presc_nxt = '0;
            w_idx_nxt   = r_idx + 2'd1;
        end else begin
            w_presc_nxt = r_presc + PW'(1);
            w_idx_nxt   = r_idx;
        end
        if (w_presc_nxt < BLANK_END) begin
            w_state_nxt = ST_BLANK;
        end else begin
            w_state_nxt = ST_SHOW;
        end
`ifdef SSD_SCAN_LZB_EN
        w_show = (r_state == ST_SHOW) && (r_idx <= top_digit(r_shadow));
`else
        w_show = (r_state == ST_SHOW);
`endif
        w_frame_nxt = (w_presc_nxt == PRESC_MAX) && (w_idx_nxt == 2'd3);
    end

    // Scan state machine with registered display outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_idx       <= 2'd0;
            r_shadow    <= 16'h0000;
            r_first     <= 1'b1;
            r_state     <= ST_RESET;
            digit_value <= 4'h0;
            digit_sel   <= 4'b0000;
            digit_blank <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
            r_first <= 1'b0;
            case (w_state_nxt)
                ST_BLANK: r_state <= ST_BLANK;
                ST_SHOW:  r_state <= ST_SHOW;
                default:  r_state <= ST_BLANK;
            endcase
            // Capture only at frame boundaries so a frame never mixes two counts.
            if (r_first || (w_wrap && (r_idx == 2'd3))) begin
                r_shadow <= value;
            end else begin
                r_shadow <= r_shadow;
            end
            digit_value <= r_shadow[{r_idx, 2'b00} +: 4];
            if (w_show) begin
                digit_sel   <= 4'b0001 << r_idx;
                digit_blank <= 1'b0;
            end else begin
                digit_sel   <= 4'b0000;
                digit_blank <= 1'b1;
            end
            frame_done <= w_frame_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux (DIV=16, 4 blank cycles) against a cycle-count reference model.
module tb_ssd_scan_mux;

    localparam int DIV   = 16;
    localparam int BL    = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] value  = 16'h0000;
    logic [3:0]  digit_value;
    logic [3:0]  digit_sel;
    logic        digit_blank;
    logic        frame_done;
    logic [9:0]  obs;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    logic [15:0] vals [0:8191];

    assign obs = {digit_value, digit_sel, digit_blank, frame_done};

    always #5 clk_in = ~clk_in;

    ssd_scan_mux #(
        .CLK_HZ      (16),
        .DIGIT_HZ    (1),
        .BLANK_CYCLES(4)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .value      (value),
        .digit_value(digit_value),
        .digit_sel  (digit_sel),
        .digit_blank(digit_blank),
        .frame_done (frame_done)
    );

    // Expected {digit_value, digit_sel, digit_blank, frame_done} after tt edges since reset release.
    function automatic logic [9:0] model(input int tt);
        int s;
        int idx;
        int presc;
        int e;
        logic [15:0] sh;
        logic        show;
        logic [3:0]  dv;
        logic [3:0]  sel;
        if (tt == 0) return 10'b0000_0000_10;
        s = tt - 1;
        if (s == 0) begin
            sh = 16'h0000;
        end else begin
            e  = (s >= FRAME) ? (s / FRAME) * FRAME : 1;
            sh = vals[e];
        end
        presc = s % DIV;
        idx   = (s / DIV) % 4;
        show  = (presc >= BL);
`ifdef SSD_SCAN_LZB_EN
        begin
            int msd;
            msd = 0;
            for (int i = 1; i < 4; i++)
                if (((sh >> (4 * i)) & 16'h000F) != 16'h0000) msd = i;
            if (idx > msd) show = 1'b0;
        end
`endif
        dv  = 4'((sh >> (4 * idx)) & 16'h000F);
        sel = show ? 4'(1 << idx) : 4'b0000;
        return {dv, sel, ~show, ((tt % FRAME) == FRAME - 1)};
    endfunction

    task automatic step(input logic [15:0] v);
        value = v;
        @(posedge clk_in);
        t++;
        vals[t] = value;
        #1;
    endtask

    task automatic release_reset(input logic [15:0] v);
        value = v;
        rst_n = 1'b1;
        t     = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        value = 16'hBEEF;
        repeat (3) begin
            @(posedge clk_in);
            #1;
            n_checks++;
            if (obs !== 10'b0000_0000_10) begin
                n_fail++;
                $display("FAIL reset got=%h want=%h", obs, 10'b0000_0000_10);
            end
        end
    endtask

    task automatic test_scan_order();
        release_reset(16'h1234);
        for (int i = 0; i < FRAME; i++) begin
            step(16'h1234);
            n_checks++;
            if (obs !== model(t)) begin
                n_fail++;
                $display("FAIL scan_order t=%0d got=%h want=%h", t, obs, model(t));
            end
        end
    endtask

    task automatic test_frame_capture();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step((t + 1 <= FRAME + DIV + 8) ? 16'h1234 : 16'h5678);
            n_checks++;
            if (obs !== model(t)) begin
                n_fail++;
                $display("FAIL frame_capture t=%0d got=%h want=%h", t, obs, model(t));
            end
        end
    endtask

    task automatic test_dead_time();
        int zrun;
        zrun = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(16'($urandom) | 16'h1000);
            n_checks++;
            if (obs !== model(t)) begin
                n_fail++;
                $display("FAIL dead_time_model t=%0d got=%h want=%h", t, obs, model(t));
            end
            n_checks++;
            if (!$onehot0(digit_sel)) begin
                n_fail++;
                $display("FAIL dead_time_onehot t=%0d got=%b want=onehot0", t, digit_sel);
            end
            if (digit_sel == 4'b0000) begin
                zrun++;
            end else if (zrun > 0) begin
                n_checks++;
                if (zrun !== BL) begin
                    n_fail++;
                    $display("FAIL dead_time_len t=%0d got=%0d want=%0d", t, zrun, BL);
                end
                zrun = 0;
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < FRAME && ((t - 1) % FRAME) != 2 * DIV + 6; i++) begin
            step(value);
            n_checks++;
            if (obs !== model(t)) begin
                n_fail++;
                $display("FAIL async_pre t=%0d got=%h want=%h", t, obs, model(t));
            end
        end
        n_checks++;
        if (digit_sel !== 4'b0100) begin
            n_fail++;
            $display("FAIL async_in_show got=%b want=%b", digit_sel, 4'b0100);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 10'b0000_0000_10) begin
            n_fail++;
            $display("FAIL async_no_edge got=%h want=%h", obs, 10'b0000_0000_10);
        end
        @(posedge clk_in);
        #1;
        release_reset(16'hA5C3);
        for (int i = 0; i < FRAME + 8; i++) begin
            step(16'hA5C3);
            n_checks++;
            if (obs !== model(t)) begin
                n_fail++;
                $display("FAIL async_restart t=%0d got=%h want=%h", t, obs, model(t));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        v = value;
        for (int i = 0; i < 5 * FRAME; i++) begin
            // Bias changes onto the capture edge to hit the wrap/change coincidence.
            if (((t + 1) % FRAME) == 0 || $urandom_range(0, 5) == 0) v = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            step(v);
            n_checks++;
            if (obs !== model(t)) begin
                n_fail++;
                $display("FAIL random t=%0d got=%h want=%h", t, obs, model(t));
            end
        end
    endtask

    task automatic test_lzb();
        rst_n = 1'b0;
        @(posedge clk_in);
        #1;
        release_reset(16'h0042);
        for (int i = 0; i < 3 * FRAME; i++) begin
            step((t + 1 <= FRAME + 6) ? 16'h0042 : 16'h0000);
            n_checks++;
            if (obs !== model(t)) begin
                n_fail++;
                $display("FAIL lzb t=%0d got=%h want=%h", t, obs, model(t));
            end
`ifdef SSD_SCAN_LZB_EN
            if (t == 2 * DIV + 9 || t == 3 * DIV + 9) begin
                n_checks++;
                if ({digit_sel, digit_blank} !== 5'b0000_1) begin
                    n_fail++;
                    $display("FAIL lzb_blank_slot t=%0d got=%b want=%b", t, {digit_sel, digit_blank}, 5'b0000_1);
                end
            end
            if (t == 2 * FRAME + 9) begin
                n_checks++;
                if ({digit_value, digit_sel} !== 8'h01) begin
                    n_fail++;
                    $display("FAIL lzb_zero t=%0d got=%h want=%h", t, {digit_value, digit_sel}, 8'h01);
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_frame_capture();
        test_dead_time();
        test_async_reset();
        test_random();
        test_lzb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
